// File: rtl/nn_pkg.sv
// Shared types and constants for the neural-network datapath blocks.
package nn_pkg;

  localparam int NN_RESULT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_DONE     = 2'd3
  } feeder_state_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/feeder_issue_ctr.sv
// Address issue counter with a one-deep read-pipeline valid and an emitted-beat count.
module feeder_issue_ctr
  import nn_pkg::*;
#(
  parameter int NUM_INPUTS = 784,
  parameter int CNT_W      = cnt_width(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             issue_req,
  output logic [CNT_W-1:0] issue_cnt,
  output logic             pipe_vld,
  output logic             last_beat
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_INPUTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_INPUTS - 1);

  logic [CNT_W-1:0] issue_cnt_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic             pipe_vld_r;
  logic             issue_fire_s;

  // Saturation at NUM_INPUTS is what stops issue; the counter never wraps.
  assign issue_fire_s = issue_req && (issue_cnt_r != CNT_FULL);

  // Issue count, beat count and pipeline valid, all cleared at each accepted start.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      issue_cnt_r <= {CNT_W{1'b0}};
      beat_cnt_r  <= {CNT_W{1'b0}};
      pipe_vld_r  <= 1'b0;
    end else begin
      pipe_vld_r <= issue_fire_s;
      if (issue_fire_s) begin
        issue_cnt_r <= issue_cnt_r + CNT_W'(1'b1);
      end
      if (pipe_vld_r) begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1'b1);
      end
    end
  end

  assign issue_cnt = issue_cnt_r;
  assign pipe_vld  = pipe_vld_r;
  assign last_beat = pipe_vld_r && (beat_cnt_r == CNT_LAST);

endmodule

// File: rtl/neuron_feeder.sv
// Streams NUM_INPUTS activation/weight pairs from two RAMs into a neuron and
// collects its result, with a bounded wait and a sticky timeout flag.
module neuron_feeder
  import nn_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int NUM_INPUTS     = 784,
  parameter int ADDR_W         = $clog2(NUM_INPUTS),
  parameter int RESULT_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  output logic [ADDR_W-1:0]      act_addr,
  input  logic [IN_WIDTH-1:0]    act_data,
  output logic [ADDR_W-1:0]      wt_addr,
  input  logic [IN_WIDTH-1:0]    wt_data,
  input  logic [IN_WIDTH-1:0]    bias,
  output logic [IN_WIDTH-1:0]    data_in,
  output logic [IN_WIDTH-1:0]    weight_in,
  output logic [IN_WIDTH-1:0]    bias_in,
  output logic                   input_valid,
  input  logic [NN_RESULT_W-1:0] nrn_data,
  input  logic                   nrn_valid,
  output logic                   busy,
  output logic [NN_RESULT_W-1:0] result,
  output logic                   result_valid,
  output logic                   timeout_err
);

  localparam int CNT_W = cnt_width(NUM_INPUTS);
  localparam int TO_W  = cnt_width(RESULT_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RESULT_TIMEOUT - 1);

  feeder_state_e          state_r, next_state_s;
  logic [CNT_W-1:0]       issue_cnt_s;
  logic                   pipe_vld_s;
  logic                   last_beat_s;
  logic                   ctr_clear_s;
  logic                   issue_req_s;
  logic                   expired_s;
  logic [TO_W-1:0]        wait_cnt_r, wait_cnt_s;
  logic                   busy_r, busy_s;
  logic [IN_WIDTH-1:0]    bias_in_r, bias_in_s;
  logic [NN_RESULT_W-1:0] result_r, result_s;
  logic                   result_valid_r, result_valid_s;
  logic                   timeout_err_r, timeout_err_s;

  feeder_issue_ctr #(
    .NUM_INPUTS (NUM_INPUTS),
    .CNT_W      (CNT_W)
  ) u_issue_ctr (
    .clk       (clk),
    .rst       (rst),
    .clear     (ctr_clear_s),
    .issue_req (issue_req_s),
    .issue_cnt (issue_cnt_s),
    .pipe_vld  (pipe_vld_s),
    .last_beat (last_beat_s)
  );

  assign expired_s = (wait_cnt_r == TO_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_ISSUE;
        else       next_state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (last_beat_s) next_state_s = ST_WAIT_RES;
        else             next_state_s = ST_ISSUE;
      end
      ST_WAIT_RES: begin
        if (nrn_valid || expired_s) next_state_s = ST_DONE;
        else                        next_state_s = ST_WAIT_RES;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM output logic: counter controls and next values of the registered outputs.
  always_comb begin
    busy_s         = busy_r;
    bias_in_s      = bias_in_r;
    result_s       = result_r;
    result_valid_s = 1'b0;
    timeout_err_s  = timeout_err_r;
    wait_cnt_s     = {TO_W{1'b0}};
    ctr_clear_s    = 1'b0;
    issue_req_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          busy_s        = 1'b1;
          bias_in_s     = bias;
          timeout_err_s = 1'b0;
          ctr_clear_s   = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        busy_s      = 1'b1;
        issue_req_s = ~pause;
      end
      ST_WAIT_RES: begin
        if (nrn_valid) begin
          result_s       = nrn_data;
          result_valid_s = 1'b1;
          busy_s         = 1'b0;
        end else if (expired_s) begin
          result_s       = {NN_RESULT_W{1'b0}};
          timeout_err_s  = 1'b1;
          result_valid_s = 1'b1;
          busy_s         = 1'b0;
        end else begin
          wait_cnt_s = wait_cnt_r + TO_W'(1'b1);
        end
      end
      ST_DONE: busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

  // Output and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r         <= 1'b0;
      bias_in_r      <= {IN_WIDTH{1'b0}};
      result_r       <= {NN_RESULT_W{1'b0}};
      result_valid_r <= 1'b0;
      timeout_err_r  <= 1'b0;
      wait_cnt_r     <= {TO_W{1'b0}};
    end else begin
      busy_r         <= busy_s;
      bias_in_r      <= bias_in_s;
      result_r       <= result_s;
      result_valid_r <= result_valid_s;
      timeout_err_r  <= timeout_err_s;
      wait_cnt_r     <= wait_cnt_s;
    end
  end

  // RAM data is forwarded in the cycle it arrives so a beat leaves two cycles after start.
  assign act_addr     = ADDR_W'(issue_cnt_s);
  assign wt_addr      = ADDR_W'(issue_cnt_s);
  assign input_valid  = pipe_vld_s;
  assign data_in      = pipe_vld_s ? act_data : {IN_WIDTH{1'b0}};
  assign weight_in    = pipe_vld_s ? wt_data  : {IN_WIDTH{1'b0}};
  assign bias_in      = bias_in_r;
  assign busy         = busy_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign timeout_err  = timeout_err_r;

endmodule
